// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: funct3 codes, memory
// control codes, FSM state encoding and access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [2:0] MEM_RD_DW_DEF = 3'b101;
    localparam logic [2:0] MEM_WR_DW_DEF = 3'b100;

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

    // Access size in bytes; unsigned variants share the low two bits with signed ones.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment over the 128-bit {hi,lo} doubleword window:
// load extract with sign/zero extension, and store byte-mask merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] buf_lo,
    input  logic [63:0] buf_hi,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] merged_lo,
    output logic [63:0] merged_hi
);

    logic [127:0] window;
    logic [127:0] win;
    logic [127:0] sh;
    logic [127:0] bytemask;
    logic [127:0] merged;
    logic [15:0]  mask16;
    logic [3:0]   size;

    // NOTE: every output and temporary is assigned on every path through this
    // block, so synthesis sees pure combinational logic and infers no latch.
    always_comb begin
        size   = size_bytes(funct3);
        window = {buf_hi, buf_lo};
        win    = window >> {off, 3'b000};

        case (funct3)
            F3_B:    load_data = {{56{win[7]}},  win[7:0]};
            F3_H:    load_data = {{48{win[15]}}, win[15:0]};
            F3_W:    load_data = {{32{win[31]}}, win[31:0]};
            F3_BU:   load_data = {56'b0, win[7:0]};
            F3_HU:   load_data = {48'b0, win[15:0]};
            F3_WU:   load_data = {32'b0, win[31:0]};
            default: load_data = win[63:0];
        endcase

        mask16 = ((16'd1 << size) - 16'd1) << off;
        for (int i = 0; i < 16; i++) begin
            bytemask[8*i +: 8] = {8{mask16[i]}};
        end
        sh        = {64'b0, wdata} << {off, 3'b000};
        merged    = (window & ~bytemask) | (sh & bytemask);
        merged_lo = merged[63:0];
        merged_hi = merged[127:64];
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator on the 64-bit data-memory port: doubleword reads,
// read-modify-write stores, and two-beat splitting of crossing accesses.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter bit         SPLIT_EN  = 1'b1,
    parameter logic [2:0] MEM_RD_DW = MEM_RD_DW_DEF,
    parameter logic [2:0] MEM_WR_DW = MEM_WR_DW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] dm_addr,
    output logic [2:0]  dm_rd_ctrl,
    output logic [2:0]  dm_wr_ctrl,
    output logic [63:0] dm_din,
    input  logic [63:0] dm_dout
);

    state_t      state_q, state_d;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [63:0] addr_q, wdata_q, buf_lo_q, buf_hi_q;
    logic [63:0] load_data, merged_lo, merged_hi;
    logic [63:0] lo_addr, hi_addr;
    logic        req_cross, req_err, cross_q, accept;

    assign req_cross = ({1'b0, req_addr[2:0]} + size_bytes(req_funct3)) > 4'd8;
    assign req_err   = (req_funct3 == 3'b111) || (req_we && req_funct3[2]) ||
                       (!SPLIT_EN && req_cross);
    assign cross_q   = ({1'b0, addr_q[2:0]} + size_bytes(f3_q)) > 4'd8;
    assign lo_addr   = {addr_q[63:3], 3'b000};
    assign hi_addr   = lo_addr + 64'd8;
    assign accept    = req_valid && req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: datapath registers carry no reset; each is written before the FSM reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= req_we;
            f3_q     <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            buf_hi_q <= '0;
        end else if (state_q == RD0) begin
            buf_lo_q <= dm_dout;
        end else if (state_q == RD1) begin
            buf_hi_q <= dm_dout;
        end
    end

    lsu_align u_align (
        .buf_lo    (buf_lo_q),
        .buf_hi    (buf_hi_q),
        .off       (addr_q[2:0]),
        .funct3    (f3_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged_lo (merged_lo),
        .merged_hi (merged_hi)
    );

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        dm_addr    = lo_addr;
        dm_rd_ctrl = 3'b000;
        dm_wr_ctrl = 3'b000;
        dm_din     = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_err ? RESP : RD0;
            end
            RD0: begin
                dm_rd_ctrl = MEM_RD_DW;
                state_d    = cross_q ? RD1 : (we_q ? WR0 : RESP);
            end
            RD1: begin
                dm_addr    = hi_addr;
                dm_rd_ctrl = MEM_RD_DW;
                state_d    = we_q ? WR0 : RESP;
            end
            WR0: begin
                dm_wr_ctrl = MEM_WR_DW;
                dm_din     = merged_lo;
                state_d    = cross_q ? WR1 : RESP;
            end
            WR1: begin
                dm_addr    = hi_addr;
                dm_wr_ctrl = MEM_WR_DW;
                dm_din     = merged_hi;
                state_d    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? 64'b0 : load_data;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset suppresses all handshakes and memory commands in the same cycle.
        if (rst) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_err   = 1'b0;
            resp_rdata = '0;
            dm_rd_ctrl = 3'b000;
            dm_wr_ctrl = 3'b000;
        end
    end

endmodule
